// File: rtl/rtlmem_1r1w_px.sv
// Simple-dual-port memory (one write, one read port) on a single clock.
// Read latency is G_PIPELINE cycles, writes take per-byte enables, and a
// same-address collision can be write-first (G_BYPASS=1) or read-first.
// A clear engine sweeps G_RST_VAL through every word after reset and on
// request; user traffic is blocked while it runs.
module rtlmem_1r1w_px #(
  parameter int unsigned         G_ADDR     = 10,
  parameter int unsigned         G_WIDTH    = 32,
  parameter int unsigned         G_DEPTH    = 2**G_ADDR,
  parameter int unsigned         G_BYTE     = 8,
  parameter int unsigned         G_PIPELINE = 2,
  parameter bit                  G_BYPASS   = 1'b1,
  parameter logic [G_WIDTH-1:0]  G_RST_VAL  = '0
) (
  input  logic                        rclk,
  input  logic                        rst_n,
  input  logic                        clren,
  output logic                        clrrdy,
  input  logic                        memwe,
  input  logic [G_WIDTH/G_BYTE-1:0]   memwbe,
  input  logic [G_ADDR-1:0]           memwa,
  input  logic [G_WIDTH-1:0]          memdi,
  input  logic                        memre,
  input  logic [G_ADDR-1:0]           memra,
  output logic [G_WIDTH-1:0]          memdo,
  output logic                        memvld
);

  localparam int unsigned NB = G_WIDTH / G_BYTE;
  // Sweep counter is one bit wider than the address so it never wraps.
  localparam int unsigned CW = G_ADDR + 1;
  // Array index width; exactly what G_DEPTH entries need.
  localparam int unsigned IW = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(G_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_X   = CW'(G_DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nxt;
  logic            clrrdy_q;
  logic            clrrdy_nxt;
  logic            sweep_we_c;
  logic            user_ok_c;

  // Write-port and read-port decode.
  logic            wr_hit_c;
  logic            arr_we_c;
  logic [IW-1:0]   arr_idx_c;
  logic [NB-1:0]   arr_be_c;
  logic [G_WIDTH-1:0] arr_dat_c;
  logic            rd_in_c;
  logic            rd_acc_c;
  logic            collide_c;
  logic [IW-1:0]   rd_idx_c;
  logic [G_WIDTH-1:0] rd_old_c;
  logic [G_WIDTH-1:0] rd_mrg_c;
  logic [G_WIDTH-1:0] rd_word_c;

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];

  // Read pipeline; the last stage drives memdo/memvld.
  logic [G_PIPELINE-1:0] vld_q;
  logic [G_WIDTH-1:0]    dat_q [G_PIPELINE];

  // Clear-engine state register.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      clrrdy_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      clrrdy_q <= clrrdy_nxt;
    end
  end

  // Clear-engine next state; clrrdy trails the READY state by one cycle.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    clrrdy_nxt = 1'b0;
    sweep_we_c = 1'b0;
    user_ok_c  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_we_c = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      ST_READY: begin
        user_ok_c = 1'b1;
        if (clren) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end else begin
          clrrdy_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign clrrdy = clrrdy_q;

  // Array write mux: the sweep owns the port while clearing.
  always_comb begin
    wr_hit_c  = user_ok_c & memwe & ({1'b0, memwa} < DEPTH_X);
    arr_we_c  = rst_n & (sweep_we_c | wr_hit_c);
    arr_idx_c = IW'(memwa);
    arr_be_c  = memwbe;
    arr_dat_c = memdi;
    if (sweep_we_c) begin
      arr_idx_c = IW'(cnt_q);
      arr_be_c  = '1;
      arr_dat_c = G_RST_VAL;
    end
  end

  // Storage array, byte-lane writes; contents are not reset directly.
  always_ff @(posedge rclk) begin
    if (arr_we_c) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (arr_be_c[b]) begin
          mem_q[arr_idx_c][b*G_BYTE +: G_BYTE] <= arr_dat_c[b*G_BYTE +: G_BYTE];
        end
      end
    end
  end

  // Read word selection: range check, then optional write-first merge.
  always_comb begin
    rd_in_c   = ({1'b0, memra} < DEPTH_X);
    rd_acc_c  = user_ok_c & memre;
    rd_idx_c  = IW'(memra);
    rd_old_c  = mem_q[rd_idx_c];
    collide_c = wr_hit_c & (memwa == memra);
    rd_mrg_c  = rd_old_c;
    for (int b = 0; b < int'(NB); b++) begin
      if (memwbe[b]) begin
        rd_mrg_c[b*G_BYTE +: G_BYTE] = memdi[b*G_BYTE +: G_BYTE];
      end
    end
    if (!rd_in_c) begin
      rd_word_c = G_RST_VAL;
    end else if (G_BYPASS && collide_c) begin
      rd_word_c = rd_mrg_c;
    end else begin
      rd_word_c = rd_old_c;
    end
  end

  // Read pipeline: data stages only load behind a valid, so memdo holds.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(G_PIPELINE); i++) begin
        dat_q[i] <= G_RST_VAL;
      end
    end else begin
      vld_q[0] <= rd_acc_c;
      if (rd_acc_c) begin
        dat_q[0] <= rd_word_c;
      end
      for (int i = 1; i < int'(G_PIPELINE); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign memdo  = dat_q[G_PIPELINE-1];
  assign memvld = vld_q[G_PIPELINE-1];

endmodule

// File: tb/tb_rtlmem_1r1w_px.sv
// Bench for rtlmem_1r1w_px: two instances share stimulus, one write-first
// with 2-cycle latency, one read-first with 1-cycle latency.
module tb_rtlmem_1r1w_px;

  localparam int DEP = 16;
  localparam int SL  = 64;

  logic        rclk;
  logic        rst_n;
  logic        clren;
  logic        memwe;
  logic [3:0]  memwbe;
  logic [4:0]  memwa;
  logic [31:0] memdi;
  logic        memre;
  logic [4:0]  memra;
  logic        clrrdy0, clrrdy1;
  logic [31:0] memdo0, memdo1;
  logic        memvld0, memvld1;

  rtlmem_1r1w_px #(
    .G_ADDR(5), .G_WIDTH(32), .G_DEPTH(16), .G_BYTE(8),
    .G_PIPELINE(2), .G_BYPASS(1'b1), .G_RST_VAL(32'h0)
  ) u_p2_wf (
    .rclk(rclk), .rst_n(rst_n), .clren(clren), .clrrdy(clrrdy0),
    .memwe(memwe), .memwbe(memwbe), .memwa(memwa), .memdi(memdi),
    .memre(memre), .memra(memra), .memdo(memdo0), .memvld(memvld0)
  );

  rtlmem_1r1w_px #(
    .G_ADDR(5), .G_WIDTH(32), .G_DEPTH(16), .G_BYTE(8),
    .G_PIPELINE(1), .G_BYPASS(1'b0), .G_RST_VAL(32'h0)
  ) u_p1_rf (
    .rclk(rclk), .rst_n(rst_n), .clren(clren), .clrrdy(clrrdy1),
    .memwe(memwe), .memwbe(memwbe), .memwa(memwa), .memdi(memdi),
    .memre(memre), .memra(memra), .memdo(memdo1), .memvld(memvld1)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int          nvec;
  int          nfail;
  int          ecnt;
  int          since;
  logic [31:0] mdl [DEP];
  bit          hv [2][SL];
  logic [31:0] hd [2][SL];
  logic [31:0] exp_do [2];
  bit          exp_vld [2];
  bit          exp_rdy;
  bit          got_v [2];
  logic [31:0] got_d [2];

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [4:0]  wa;
    logic [31:0] di;
    logic        re;
    logic [4:0]  ra;
    logic [31:0] e_wf;
    logic [31:0] e_rf;
  } vec_t;

  vec_t tv [12];

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = di[b*8 +: 8];
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  // Reference: memory is usable once 16 sweep edges have passed since the
  // last clear start; results are scheduled by edge number in a time wheel.
  task automatic model_edge();
    bit          rdy;
    logic [31:0] w;
    int          slot;
    ecnt++;
    if (!rst_n) begin
      since = 0;
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < SL; s++) hv[k][s] = 1'b0;
        exp_do[k]  = 32'h0;
        exp_vld[k] = 1'b0;
      end
      for (int a = 0; a < DEP; a++) mdl[a] = 32'h0;
      exp_rdy = 1'b0;
    end else begin
      rdy = (since >= DEP);
      if (rdy && memre) begin
        for (int k = 0; k < 2; k++) begin
          if (int'(memra) >= DEP) w = 32'h0;
          else if (k == 0 && memwe && memwa == memra) w = merge(mdl[memra[3:0]], memdi, memwbe);
          else w = mdl[memra[3:0]];
          slot = (ecnt + lat(k) - 1) % SL;
          hv[k][slot] = 1'b1;
          hd[k][slot] = w;
        end
      end
      if (rdy && memwe && int'(memwa) < DEP)
        mdl[memwa[3:0]] = merge(mdl[memwa[3:0]], memdi, memwbe);
      if (rdy && clren) begin
        since = 0;
        for (int a = 0; a < DEP; a++) mdl[a] = 32'h0;
      end else if (since < 1000) begin
        since++;
      end
      exp_rdy = (since > DEP);
      for (int k = 0; k < 2; k++) begin
        slot = ecnt % SL;
        exp_vld[k] = hv[k][slot];
        if (hv[k][slot]) begin
          exp_do[k]   = hd[k][slot];
          hv[k][slot] = 1'b0;
        end
      end
    end
  endtask

  // One clock: update the model, take the edge, check every output.
  task automatic tick();
    model_edge();
    @(posedge rclk);
    #1;
    cmp("clrrdy_wf", 32'(clrrdy0), 32'(exp_rdy));
    cmp("clrrdy_rf", 32'(clrrdy1), 32'(exp_rdy));
    cmp("memvld_wf", 32'(memvld0), 32'(exp_vld[0]));
    cmp("memvld_rf", 32'(memvld1), 32'(exp_vld[1]));
    cmp("memdo_wf", memdo0, exp_do[0]);
    cmp("memdo_rf", memdo1, exp_do[1]);
    if (memvld0 === 1'b1) begin got_v[0] = 1'b1; got_d[0] = memdo0; end
    if (memvld1 === 1'b1) begin got_v[1] = 1'b1; got_d[1] = memdo1; end
  endtask

  task automatic idle();
    memwe = 1'b0;
    memre = 1'b0;
    clren = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEP; a++) begin
      memre = 1'b1;
      memra = 5'(a);
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  // Counts edges until clrrdy rises, reading while the sweep runs.
  task automatic wait_ready(output int n, input bit wr_noise);
    n = 0;
    while (n < 40) begin
      memre  = (n < 14);
      memra  = 5'($urandom_range(0, 15));
      memwe  = wr_noise && (n < 14);
      memwa  = 5'($urandom_range(0, 15));
      memwbe = 4'hF;
      memdi  = $urandom;
      clren  = wr_noise && (n == 7);
      tick();
      n++;
      if (clrrdy0 === 1'b1) break;
    end
    idle();
  endtask

  initial begin
    int n;
    nvec  = 0;
    nfail = 0;
    ecnt  = 0;
    since = 0;
    exp_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_do[k] = 32'h0; exp_vld[k] = 1'b0; got_v[k] = 1'b0; got_d[k] = 32'h0;
      for (int s = 0; s < SL; s++) begin hv[k][s] = 1'b0; hd[k][s] = 32'h0; end
    end
    for (int a = 0; a < DEP; a++) mdl[a] = 32'h0;

    tv[0]  = '{1'b1, 4'hF, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF, 32'h00000000};
    tv[1]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 4'hF, 5'd3,  32'h11223344, 1'b0, 5'd0,  32'h00000000, 32'h00000000};
    tv[3]  = '{1'b1, 4'h5, 5'd3,  32'hAABBCCDD, 1'b0, 5'd0,  32'h00000000, 32'h00000000};
    tv[4]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd3,  32'h11BB33DD, 32'h11BB33DD};
    tv[5]  = '{1'b1, 4'hF, 5'd7,  32'h12345678, 1'b1, 5'd7,  32'h12345678, 32'h00000000};
    tv[6]  = '{1'b1, 4'h0, 5'd7,  32'hFFFFFFFF, 1'b1, 5'd7,  32'h12345678, 32'h12345678};
    tv[7]  = '{1'b1, 4'hF, 5'd20, 32'hCAFEF00D, 1'b1, 5'd20, 32'h00000000, 32'h00000000};
    tv[8]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd4,  32'h00000000, 32'h00000000};
    tv[9]  = '{1'b1, 4'h8, 5'd7,  32'h99000000, 1'b1, 5'd7,  32'h99345678, 32'h12345678};
    tv[10] = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd7,  32'h99345678, 32'h99345678};
    tv[11] = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd31, 32'h00000000, 32'h00000000};

    rst_n = 1'b0; clren = 1'b0; memwe = 1'b0; memre = 1'b0;
    memwbe = 4'h0; memwa = 5'd0; memdi = 32'h0; memra = 5'd0;
    repeat (3) tick();

    // Reset release: sweep length, then every word reads back as zero.
    rst_n = 1'b1;
    wait_ready(n, 1'b0);
    cmp("rst_clr_len", 32'(n), 32'd17);
    repeat (2) tick();
    read_all();

    // Directed single-cycle vectors with known results.
    for (int i = 0; i < 12; i++) begin
      memwe = tv[i].we; memwbe = tv[i].be; memwa = tv[i].wa; memdi = tv[i].di;
      memre = tv[i].re; memra = tv[i].ra;
      got_v[0] = 1'b0; got_v[1] = 1'b0;
      tick();
      idle();
      repeat (3) tick();
      if (tv[i].re) begin
        cmp($sformatf("tbl%0d_vld_wf", i), 32'(got_v[0]), 32'd1);
        cmp($sformatf("tbl%0d_do_wf", i), got_d[0], tv[i].e_wf);
        cmp($sformatf("tbl%0d_vld_rf", i), 32'(got_v[1]), 32'd1);
        cmp($sformatf("tbl%0d_do_rf", i), got_d[1], tv[i].e_rf);
      end
    end

    // Fill, then clear request with writes and a second clren mid-sweep.
    for (int a = 0; a < DEP; a++) begin
      memwe = 1'b1; memwbe = 4'hF; memwa = 5'(a); memdi = $urandom | 32'h1;
      tick();
    end
    idle();
    read_all();
    clren = 1'b1;
    tick();
    idle();
    wait_ready(n, 1'b1);
    cmp("clren_clr_len", 32'(n), 32'd17);
    repeat (2) tick();
    read_all();

    // Reset landing on sweep address 9 restarts the sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (9) tick();
    rst_n = 1'b0;
    memre = 1'b1; memra = 5'd3;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(n, 1'b0);
    cmp("rst9_clr_len", 32'(n), 32'd17);
    memre = 1'b1; memra = 5'd20;
    got_v[0] = 1'b0; got_v[1] = 1'b0; got_d[0] = 32'hFFFFFFFF; got_d[1] = 32'hFFFFFFFF;
    tick();
    idle();
    repeat (3) tick();
    cmp("oor20_vld_wf", 32'(got_v[0]), 32'd1);
    cmp("oor20_do_wf", got_d[0], 32'h0);
    cmp("oor20_do_rf", got_d[1], 32'h0);

    // Random traffic with occasional clear requests and resets.
    for (int i = 0; i < 1500; i++) begin
      rst_n  = ($urandom_range(0, 399) != 0);
      clren  = ($urandom_range(0, 99) == 0);
      memwe  = 1'($urandom_range(0, 1));
      memwbe = 4'($urandom);
      memwa  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 15));
      memdi  = $urandom;
      memre  = 1'($urandom_range(0, 1));
      memra  = ($urandom_range(0, 3) == 0) ? memwa :
               (($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 15)));
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rtlmem_1r1w_px.md
Name: rtlmem_1r1w_px

Overview:
- Single-clock simple-dual-port memory: one write port, one read port.
- Read latency is configurable (G_PIPELINE), with byte-enable writes and a selectable write-first bypass.
- Built-in clear engine sweeps G_RST_VAL into every location after reset and on request.
- Drop-in successor for fixed-latency 1R1W wrappers in datapath buffers and lookup tables; the array is inferred.

Parameters:
- G_ADDR, 10, address width.
- G_WIDTH, 32, data width; must be a multiple of G_BYTE.
- G_DEPTH, 2**G_ADDR, number of words; G_DEPTH <= 2**G_ADDR.
- G_BYTE, 8, bits per byte-enable lane.
- G_PIPELINE, 2, read latency in cycles; legal range 1..4.
- G_BYPASS, 1, 1 = write-first on same-cycle address collision, 0 = read-first.
- G_RST_VAL, {G_WIDTH{1'b0}}, clear/reset data value.

Ports:
- rclk  in  1  clock; all logic in this single domain.
- rst_n  in  1  reset, synchronous, active-low.
- clren  in  1  clear request pulse.
- clrrdy  out  1  1 = clear engine idle, memory usable.
- memwe  in  1  write enable.
- memwbe  in  G_WIDTH/G_BYTE  byte enables; bit i covers memdi[i*G_BYTE +: G_BYTE].
- memwa  in  G_ADDR  write address.
- memdi  in  G_WIDTH  write data.
- memre  in  1  read enable.
- memra  in  G_ADDR  read address.
- memdo  out  G_WIDTH  read data.
- memvld  out  1  memdo valid strobe.

Behaviour:
- Reset, synchronous on rclk while rst_n=0:
  - clrrdy=0, memvld=0, memdo=G_RST_VAL.
  - All read pipeline valid bits = 0; data stages = G_RST_VAL.
  - State = CLEAR, sweep counter = 0.
  - Array contents are not reset directly; the sweep covers them.
- State machine, two states:
  - CLEAR: each cycle writes G_RST_VAL (all bytes) to address = counter, then counter++. After the write of address G_DEPTH-1, go to READY. clrrdy goes to 1 on the cycle after that last write, i.e. G_DEPTH+1 cycles after rst_n rises or after the clren sampling edge.
  - READY: clrrdy=1. clren=1 at a rising edge gives CLEAR on the next cycle: clrrdy=0, counter=0.
  - clren while in CLEAR is ignored; the sweep is not restarted.
  - Reset mid-sweep: sweep restarts from address 0.
- In CLEAR:
  - memwe and memre are ignored; no user write lands.
  - No new read enters the pipeline.
  - Reads already in flight complete normally with pre-clear data.
- Write (READY, memwe=1):
  - At the edge, bytes whose memwbe bit is 1 take memdi; other bytes are unchanged.
  - memwa >= G_DEPTH: write dropped.
  - memwbe=0: no change.
- Read (READY, memre=1):
  - Array is sampled at the accepting edge (stage 1).
  - memdo/memvld are updated at edge G_PIPELINE, counting the accepting edge as 1. G_PIPELINE=1 means data is visible in the cycle after memre.
  - memvld is a one-cycle pulse per accepted read. Back-to-back reads give full throughput, one result per cycle, in order.
  - memdo holds its last value when memvld=0; it is not zeroed.
  - memra >= G_DEPTH: returns G_RST_VAL with memvld=1.
- Collision, same cycle, memwe & memre, memwa == memra:
  - G_BYPASS=1: result is the merged word (enabled bytes from memdi, others old).
  - G_BYPASS=0: result is the old word.
  - A write in a later cycle never alters a read already in flight.
- Width rules:
  - Sweep counter is G_ADDR+1 bits so it cannot wrap when G_DEPTH = 2**G_ADDR.
  - Compare G_DEPTH-1 explicitly; non-power-of-2 depths are legal.

Test Plan:
- Reset release, G_DEPTH=16 -> clrrdy=0 for 17 cycles then 1; reading all 16 addresses returns 0x00000000 with memvld on each.
- G_PIPELINE=2: write 0xDEADBEEF @5, then memre @5 in cycle t -> memvld=1, memdo=0xDEADBEEF in cycle t+2 only; memdo holds afterwards.
- Byte enables: word @3 = 0x11223344, write memwbe=4'b0101 data 0xAABBCCDD -> read @3 returns 0x11BB33DD.
- Collision: @7 = 0x0, same cycle write 0x12345678 (memwbe=4'hF) and read @7 -> G_BYPASS=1 gives 0x12345678; G_BYPASS=0 gives 0x00000000.
- clren pulse in READY after filling memory -> clrrdy low 17 cycles, writes during the sweep are dropped; a second clren mid-sweep does not extend it; all reads return 0 afterwards.
- rst_n asserted at sweep address 9, released -> sweep restarts at 0; clrrdy rises 17 cycles after release; memvld=0 throughout; read of out-of-range address 20 (G_ADDR=5, G_DEPTH=16) returns G_RST_VAL.
